// File: rtl/verinject_pkg.sv
// Shared definitions for the flop fault-injection controller: FSM encoding,
// command record layout and the default "no injection" value.
package verinject_pkg;

  // Value broadcast on the injector bus when nothing is being flipped.
  localparam logic [31:0] IdleStateDefault = 32'hFFFF_FFFF;

  // Width of one queued command record (bit 32 + delay 32 + duration 16).
  localparam int unsigned CmdWidth = 80;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StInject
  } fsm_state_e;

  typedef struct packed {
    logic [31:0] bit_idx;
    logic [31:0] delay;
    logic [15:0] duration;
  } cmd_t;

  // Hold counter preload: a zero duration still injects for one cycle.
  function automatic logic [31:0] hold_count(input logic [15:0] duration);
    return (duration == 16'd0) ? 32'd0 : {16'd0, duration - 16'd1};
  endfunction

endpackage

// File: rtl/verinject_cmd_fifo.sv
// Synchronous command FIFO with flush; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module verinject_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 80
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  // Pointer update: reset and flush both empty the queue.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/verinject_ff_inject_controller.sv
// Fault-injection controller: queues flop-flip commands, waits a programmed
// delay after each pop, then drives the target bit index onto the injector
// bus for the programmed duration.
module verinject_ff_inject_controller
  import verinject_pkg::*;
#(
  parameter int unsigned MAX_BIT    = 1024,
  parameter logic [31:0] IDLE_STATE = IdleStateDefault,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_bit,
  input  logic [31:0] cmd_delay,
  input  logic [15:0] cmd_duration,
  input  logic        abort,
  output logic [31:0] verinject__injector_state,
  output logic        busy,
  output logic        inject_active,
  output logic        done,
  output logic        cmd_error,
  output logic [31:0] injection_count
);

  localparam logic [31:0] MaxBitW = 32'(MAX_BIT);

  fsm_state_e r_state, w_state_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [31:0] r_bit, w_bit_d;
  logic [15:0] r_dur, w_dur_d;
  logic [31:0] r_out, w_out_d;
  logic [31:0] r_count, w_count_d;
  logic        r_done, w_done_d;
  logic        r_err;

  logic                w_full;
  logic                w_empty;
  logic                w_hs;
  logic                w_in_range;
  logic                w_push;
  logic                w_pop;
  logic [CmdWidth-1:0] w_head_raw;
  cmd_t                w_head;
  cmd_t                w_new_cmd;

  assign cmd_ready  = !w_full && !abort;
  assign w_hs       = cmd_valid && cmd_ready;
  assign w_in_range = (cmd_bit < MaxBitW);
  assign w_push     = w_hs && w_in_range;
  assign w_head     = w_head_raw;
  assign w_new_cmd  = '{bit_idx: cmd_bit, delay: cmd_delay, duration: cmd_duration};

  verinject_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CmdWidth)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_flush (abort),
    .i_push  (w_push),
    .i_wdata (w_new_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state logic: sequencing of pop, delay countdown and injection hold.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_dur_d   = r_dur;
    w_out_d   = r_out;
    w_count_d = r_count;
    w_done_d  = 1'b0;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_cnt_d   = w_head.delay;
          w_bit_d   = w_head.bit_idx;
          w_dur_d   = w_head.duration;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (r_cnt != 32'd0) begin
          w_cnt_d = r_cnt - 32'd1;
        end else begin
          w_state_d = StInject;
          w_out_d   = r_bit;
          w_cnt_d   = hold_count(r_dur);
          if (r_count != 32'hFFFF_FFFF) w_count_d = r_count + 32'd1;
        end
      end
      StInject: begin
        if (r_cnt != 32'd0) begin
          w_cnt_d = r_cnt - 32'd1;
        end else begin
          w_out_d  = IDLE_STATE;
          w_done_d = 1'b1;
          // Chaining straight into WAIT still leaves at least one idle cycle
          // on the bus, because WAIT always spends one edge before injecting.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_cnt_d   = w_head.delay;
            w_bit_d   = w_head.bit_idx;
            w_dur_d   = w_head.duration;
            w_state_d = StWait;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Abort overrides everything except reset; the count is left untouched.
    if (abort) begin
      w_state_d = StIdle;
      w_cnt_d   = 32'd0;
      w_out_d   = IDLE_STATE;
      w_done_d  = 1'b0;
      w_pop     = 1'b0;
      w_count_d = r_count;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 32'd0;
      r_bit   <= 32'd0;
      r_dur   <= 16'd0;
      r_out   <= IDLE_STATE;
      r_count <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_dur   <= w_dur_d;
      r_out   <= w_out_d;
      r_count <= w_count_d;
      r_done  <= w_done_d;
      r_err   <= w_hs && !w_in_range;
    end
  end

  assign verinject__injector_state = r_out;
  assign injection_count           = r_count;
  assign done                      = r_done;
  assign cmd_error                 = r_err;
  assign busy                      = (r_state != StIdle) || !w_empty;
  assign inject_active             = (r_out != IDLE_STATE);

endmodule

// File: tb/tb_verinject_ff_inject_controller.sv
// Directed bench for the fault-injection controller (default parameters).
module tb_verinject_ff_inject_controller;

  localparam logic [31:0] Idle = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_bit;
  logic [31:0] cmd_delay;
  logic [15:0] cmd_duration;
  logic        abort;
  logic [31:0] inj_state;
  logic        busy;
  logic        inject_active;
  logic        done;
  logic        cmd_error;
  logic [31:0] injection_count;

  int n_total = 0;
  int n_bad   = 0;

  // Injection monitor: records each new non-idle value and flags any
  // direct transition between two injections without an idle cycle.
  logic        mon_en = 1'b0;
  logic [31:0] mon_prev = 32'hFFFF_FFFF;
  logic [31:0] mon_q[$];
  int          mon_adj = 0;

  verinject_ff_inject_controller #(
    .MAX_BIT    (1024),
    .IDLE_STATE (32'hFFFF_FFFF),
    .DEPTH      (4)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .cmd_valid                 (cmd_valid),
    .cmd_ready                 (cmd_ready),
    .cmd_bit                   (cmd_bit),
    .cmd_delay                 (cmd_delay),
    .cmd_duration              (cmd_duration),
    .abort                     (abort),
    .verinject__injector_state (inj_state),
    .busy                      (busy),
    .inject_active             (inject_active),
    .done                      (done),
    .cmd_error                 (cmd_error),
    .injection_count           (injection_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mon_en) begin
      if (inj_state != Idle && inj_state != mon_prev) begin
        if (mon_prev != Idle) mon_adj++;
        mon_q.push_back(inj_state);
      end
      mon_prev = inj_state;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Offers one command for exactly one edge.
  task automatic send(input logic [31:0] b, input logic [31:0] d, input logic [15:0] l);
    cmd_valid    = 1'b1;
    cmd_bit      = b;
    cmd_delay    = d;
    cmd_duration = l;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; cmd_valid = 1'b0; cmd_bit = '0; cmd_delay = '0;
    cmd_duration = '0; abort = 1'b0;
    step(2);
    reset = 1'b0;

    // Reset state
    chk("rst_out", inj_state, Idle);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_active", {31'd0, inject_active}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, cmd_error}, 32'd0);
    chk("rst_count", injection_count, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Single shot: accepted at A, pop A+1, bit visible after A+5 and A+6
    send(32'd5, 32'd3, 16'd2);
    chk("ss_busy", {31'd0, busy}, 32'd1);
    step(4);
    chk("ss_pre", inj_state, Idle);
    step(1);
    chk("ss_on1", inj_state, 32'd5);
    chk("ss_active", {31'd0, inject_active}, 32'd1);
    chk("ss_count", injection_count, 32'd1);
    step(1);
    chk("ss_on2", inj_state, 32'd5);
    chk("ss_done_lo", {31'd0, done}, 32'd0);
    step(1);
    chk("ss_off", inj_state, Idle);
    chk("ss_done", {31'd0, done}, 32'd1);
    step(1);
    chk("ss_done_pulse", {31'd0, done}, 32'd0);
    chk("ss_idle_busy", {31'd0, busy}, 32'd0);

    // Zero delay / zero duration: one cycle of bit 0 after A+2
    send(32'd0, 32'd0, 16'd0);
    step(1);
    chk("zd_pre", inj_state, Idle);
    step(1);
    chk("zd_on", inj_state, 32'd0);
    step(1);
    chk("zd_off", inj_state, Idle);
    chk("zd_done", {31'd0, done}, 32'd1);
    chk("zd_count", injection_count, 32'd2);

    // Range check
    send(32'd1024, 32'd0, 16'd1);
    chk("rg_err", {31'd0, cmd_error}, 32'd1);
    chk("rg_busy", {31'd0, busy}, 32'd0);
    step(1);
    chk("rg_err_pulse", {31'd0, cmd_error}, 32'd0);
    chk("rg_busy2", {31'd0, busy}, 32'd0);
    send(32'd1023, 32'd0, 16'd1);
    chk("rg_ok_err", {31'd0, cmd_error}, 32'd0);
    step(1);
    step(1);
    chk("rg_on", inj_state, 32'd1023);
    step(1);
    chk("rg_off", inj_state, Idle);
    chk("rg_count", injection_count, 32'd3);

    // Back-pressure: one long-delay command in WAIT, then 5 back-to-back
    mon_q.delete();
    mon_adj  = 0;
    mon_prev = Idle;
    mon_en   = 1'b1;
    send(32'd7, 32'd10, 16'd1);
    step(1);
    send(32'd11, 32'd0, 16'd1);
    send(32'd12, 32'd0, 16'd1);
    send(32'd13, 32'd0, 16'd1);
    send(32'd14, 32'd0, 16'd1);
    chk("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_bit = 32'd15; cmd_delay = 32'd0; cmd_duration = 16'd1;
    guard = 0;
    while (!cmd_ready && guard < 40) begin
      step(1);
      guard++;
    end
    chk("bp_ready_wait", 32'(guard), 32'd8);
    step(1);
    cmd_valid = 1'b0;
    step(15);
    mon_en = 1'b0;
    chk("bp_n", 32'(mon_q.size()), 32'd6);
    if (mon_q.size() == 6) begin
      chk("bp_q0", mon_q[0], 32'd7);
      chk("bp_q1", mon_q[1], 32'd11);
      chk("bp_q2", mon_q[2], 32'd12);
      chk("bp_q3", mon_q[3], 32'd13);
      chk("bp_q4", mon_q[4], 32'd14);
      chk("bp_q5", mon_q[5], 32'd15);
    end
    chk("bp_gap", 32'(mon_adj), 32'd0);
    chk("bp_count", injection_count, 32'd9);
    chk("bp_busy", {31'd0, busy}, 32'd0);

    // Abort during INJECT with two commands queued
    send(32'd20, 32'd0, 16'd5);
    step(1);
    send(32'd21, 32'd0, 16'd1);
    send(32'd22, 32'd0, 16'd1);
    chk("ab_pre", inj_state, 32'd20);
    abort = 1'b1;
    #1;
    chk("ab_ready", {31'd0, cmd_ready}, 32'd0);
    step(1);
    abort = 1'b0;
    chk("ab_out", inj_state, Idle);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_count", injection_count, 32'd10);
    chk("ab_active", {31'd0, inject_active}, 32'd0);
    step(6);
    chk("ab_later_out", inj_state, Idle);
    chk("ab_later_count", injection_count, 32'd10);

    // Reset mid-WAIT, with a command offered during reset
    mon_q.delete();
    mon_prev = Idle;
    mon_en   = 1'b1;
    send(32'd30, 32'd5, 16'd1);
    step(2);
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_bit = 32'd31; cmd_delay = 32'd0; cmd_duration = 16'd1;
    step(1);
    reset = 1'b0;
    cmd_valid = 1'b0;
    chk("rw_out", inj_state, Idle);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_count", injection_count, 32'd0);
    chk("rw_done", {31'd0, done}, 32'd0);
    chk("rw_err", {31'd0, cmd_error}, 32'd0);
    step(12);
    mon_en = 1'b0;
    chk("rw_no_inject", 32'(mon_q.size()), 32'd0);
    chk("rw_count_late", injection_count, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/verinject_ff_inject_controller.md
VERINJECT_FF_INJECT_CONTROLLER -- requirements
Module: verinject_ff_inject_controller

Interface
REQ-001 SHALL have parameter MAX_BIT, default 1024: total number of injectable flop bits; valid indices are 0..MAX_BIT-1.
REQ-002 SHALL have parameter IDLE_STATE, default 32'hFFFF_FFFF: no-injection value, required to be >= MAX_BIT.
REQ-003 SHALL have parameter DEPTH, default 4: command FIFO entries, a power of two >= 2.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted on an edge where cmd_valid && cmd_ready.
REQ-008 cmd_bit  input  32  global flop bit index to flip.
REQ-009 cmd_delay  input  32  cycles to wait after FIFO pop before injecting.
REQ-010 cmd_duration  input  16  cycles to hold the injection; 0 treated as 1.
REQ-011 abort  input  1  cancels the active command and flushes the FIFO.
REQ-012 verinject__injector_state  output  32  registered; drives every verinject_ff_injector in the design.
REQ-013 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-014 inject_active  output  1  high while verinject__injector_state != IDLE_STATE.
REQ-015 done  output  1  one-cycle pulse when an injection completes normally.
REQ-016 cmd_error  output  1  one-cycle pulse, cycle after an out-of-range command handshake.
REQ-017 injection_count  output  32  injections started since reset, saturating at 32'hFFFF_FFFF.

Function
REQ-018 cmd_ready SHALL equal (FIFO not full) && !abort.
REQ-019 On handshake with cmd_bit >= MAX_BIT, the command SHALL be discarded, not enqueued, and cmd_error pulsed next cycle.
REQ-020 Valid handshakes SHALL enqueue {cmd_bit, cmd_delay, cmd_duration}; a command accepted at edge A is poppable at edge A+1 at the earliest (no bypass).
REQ-021 FSM states: IDLE, WAIT, INJECT.
REQ-022 IDLE: FIFO non-empty -> pop, load delay counter = cmd_delay, go WAIT.
REQ-023 WAIT: counter != 0 -> decrement; counter == 0 -> go INJECT, load verinject__injector_state = cmd_bit, duration counter = max(cmd_duration,1)-1, increment injection_count.
REQ-024 INJECT: counter != 0 -> decrement, hold state; counter == 0 -> load verinject__injector_state = IDLE_STATE, pulse done next cycle, then pop directly into WAIT if FIFO non-empty, else go IDLE.
REQ-025 Consequence: with delay D and duration L (L >= 1), pop at edge P, the output SHALL equal cmd_bit for exactly L cycles starting after edge P+D+1.
REQ-026 Successive injections SHALL be separated by at least one cycle of IDLE_STATE.
REQ-027 FIFO push and pop in the same edge SHALL both take effect; the full/empty flags SHALL remain consistent.
REQ-028 abort SHALL take precedence over every other event: at that edge FIFO flushed, FSM -> IDLE, output -> IDLE_STATE, no done pulse, injection_count unchanged.
REQ-029 verinject__injector_state SHALL change only on clock edges (glitch-free registered output).

Reset
REQ-030 Reset SHALL set verinject__injector_state = IDLE_STATE, FSM = IDLE, FIFO empty, all counters 0, and done, cmd_error, busy, inject_active = 0.
REQ-031 Reset SHALL have priority over abort and handshakes; a command offered during reset SHALL be dropped, and reset mid-injection SHALL clear the output at that edge.

Structure
REQ-032 A shared package verinject_pkg SHALL hold the FSM state encoding, the command record layout (bit 32 / delay 32 / duration 16) and the IDLE_STATE default constant.
REQ-033 The FIFO SHALL be one sub-module, verinject_cmd_fifo (parameter DEPTH, width 80, synchronous reset, push/pop/full/empty).

Verification
REQ-034 Single shot: bit=5, delay=3, duration=2 accepted at edge 10 -> output 5 after edges 15 and 16; IDLE_STATE after edge 17; done high the cycle after edge 17; count=1.
REQ-035 Zero duration: bit=0, delay=0, duration=0 accepted at edge 4 -> output 0 for one cycle after edge 6 only.
REQ-036 Range check (MAX_BIT=1024): bit=1024 -> cmd_error pulse, no enqueue, busy stays 0; bit=1023 -> injected normally.
REQ-037 Back-pressure: 5 commands offered back-to-back, DEPTH=4, FSM busy -> cmd_ready drops after 4 accepts, the 5th accepted on the first pop edge; all 5 inject in order with >= 1 idle cycle between them.
REQ-038 Abort: abort during INJECT with 2 commands queued -> output IDLE_STATE next cycle, FIFO empty, no done, busy 0, count unchanged.
REQ-039 Reset mid-WAIT: reset asserted -> all outputs at reset values next cycle; the pending command never injects.
